// File: rtl/axi_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_id_pkg
//  Description : Shared definitions for the AXI ID allocator. Holds the default
//                pool size and the rotating first-free search used by the
//                allocator's priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_id_pkg;

    // Default number of IDs in the pool.
    localparam int unsigned ID_POOL_LEN = 16;

    // Upper bound on the pool size supported by the shared search function.
    // The search operates on a fixed-width vector so that one function
    // serves every pool size up to this limit.
    localparam int unsigned ID_MAX_LEN  = 1024;
    localparam int unsigned ID_MAX_IDW  = 10;

    typedef struct packed {
        logic                  found;
        logic [ID_MAX_IDW-1:0] index;
    } ff_result_t;

    // Returns the first set bit of vec[len-1:0], scanning start, start+1, ...
    // and wrapping at len. The loop bound is constant; positions at or beyond
    // len are skipped so the function folds down to a len-wide encoder once
    // len is a constant at the call site.
    function automatic ff_result_t rot_first_free(
        input logic [ID_MAX_LEN-1:0] vec,
        input int unsigned           start,
        input int unsigned           len
    );
        ff_result_t            res;
        int unsigned           idx;
        logic [ID_MAX_IDW-1:0] idx_w;
        res = '0;
        for (int unsigned k = 0; k < ID_MAX_LEN; k++) begin
            if (k < len) begin
                idx = start + k;
                if (idx >= len) begin
                    idx = idx - len;
                end
                idx_w = ID_MAX_IDW'(idx);
                if (!res.found && vec[idx_w]) begin
                    res.found = 1'b1;
                    res.index = idx_w;
                end
            end
        end
        return res;
    endfunction

endpackage : axi_id_pkg
`default_nettype wire

// File: rtl/rr_find_first.sv
`default_nettype none
// ============================================================================
//  Module      : rr_find_first
//  Description : Combinational rotating priority encoder. Finds the first set
//                bit of a LEN-wide vector, starting at a given position and
//                wrapping around at LEN.
//  Ports       : free_vec_i - candidate vector (1 = free)
//                start_i    - position where the search starts (< LEN)
//                found_o    - at least one bit of free_vec_i is set
//                index_o    - position of the first set bit (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_find_first
    import axi_id_pkg::*;
#(
    parameter int unsigned LEN    = ID_POOL_LEN,
    parameter int unsigned IDSIZE = $clog2(LEN)
) (
    input  logic [LEN-1:0]    free_vec_i,
    input  logic [IDSIZE-1:0] start_i,
    output logic              found_o,
    output logic [IDSIZE-1:0] index_o
);

    logic [ID_MAX_LEN-1:0] w_vec_ext;
    ff_result_t            w_res;
    logic                  w_unused_index;

    assign w_vec_ext = ID_MAX_LEN'(free_vec_i);

    always_comb begin
        w_res = rot_first_free(w_vec_ext, 32'(start_i), LEN);
    end

    assign found_o = w_res.found;
    assign index_o = w_res.index[IDSIZE-1:0];

    // Upper index bits are always zero for pools narrower than the maximum.
    assign w_unused_index = ^w_res.index;

endmodule : rr_find_first
`default_nettype wire

// File: rtl/axi_id_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : axi_id_alloc
//  Description : AXI transaction ID allocator. Offers free IDs through a
//                valid/ready handshake, takes them back on release, and
//                drives the set/clear strobes of the downstream per-ID
//                outstanding scoreboard. A rotating search pointer keeps a
//                just-released ID from being reissued straight away.
//  Ports       : clock, rst_n      - clock, async active-low reset
//                alloc_vld/id/rdy  - ID offer handshake towards the issuer
//                free_vld/free_id  - ID release strobe
//                set_vld/set_id    - scoreboard set strobe (one cycle after grant)
//                clear_vld/clear_id- scoreboard clear strobe (one cycle after release)
//                outstanding       - number of busy IDs
//                exhausted / idle  - all IDs busy / no ID busy
//                err_free          - one-cycle pulse after an illegal release
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_id_alloc
    import axi_id_pkg::*;
#(
    parameter int unsigned LEN    = ID_POOL_LEN,
    parameter int unsigned IDSIZE = $clog2(LEN)
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic              alloc_vld,
    output logic [IDSIZE-1:0] alloc_id,
    input  logic              alloc_rdy,
    input  logic              free_vld,
    input  logic [IDSIZE-1:0] free_id,
    output logic              set_vld,
    output logic [IDSIZE-1:0] set_id,
    output logic              clear_vld,
    output logic [IDSIZE-1:0] clear_id,
    output logic [IDSIZE:0]   outstanding,
    output logic              exhausted,
    output logic              idle,
    output logic              err_free
);

    localparam logic [IDSIZE:0]   C_LEN_CNT = (IDSIZE+1)'(LEN);
    localparam logic [IDSIZE-1:0] C_LAST_ID = IDSIZE'(LEN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LEN-1:0]    busy_q,        busy_d;
    logic [IDSIZE-1:0] ptr_q,         ptr_d;
    logic              alloc_vld_q,   alloc_vld_d;
    logic [IDSIZE-1:0] alloc_id_q,    alloc_id_d;
    logic              set_vld_q,     set_vld_d;
    logic [IDSIZE-1:0] set_id_q,      set_id_d;
    logic              clear_vld_q,   clear_vld_d;
    logic [IDSIZE-1:0] clear_id_q,    clear_id_d;
    logic [IDSIZE:0]   outstanding_q, outstanding_d;
    logic              exhausted_q,   exhausted_d;
    logic              idle_q,        idle_d;
    logic              err_free_q,    err_free_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_grant;
    logic              w_hold;
    logic              w_free_in_range;
    logic              w_free_busy;
    logic              w_double_free;
    logic              w_free_ok;
    logic [LEN-1:0]    w_alloc_oh;
    logic [LEN-1:0]    w_free_oh;
    logic [LEN-1:0]    w_free_vec;
    logic              w_found;
    logic [IDSIZE-1:0] w_index;

    always_comb begin
        w_grant         = alloc_vld_q & alloc_rdy;
        // An un-accepted offer must stay stable until the issuer takes it.
        w_hold          = alloc_vld_q & ~alloc_rdy;
        w_free_in_range = ({1'b0, free_id} < C_LEN_CNT);

        w_alloc_oh = '0;
        w_free_oh  = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            w_alloc_oh[i] = (alloc_id_q == IDSIZE'(i));
            w_free_oh[i]  = (free_id    == IDSIZE'(i));
        end

        w_free_busy   = |(w_free_oh & busy_q);
        // Releasing the ID that is being granted in the same cycle is a
        // double free: the issuer cannot hold a response for it yet.
        w_double_free = w_grant & (free_id == alloc_id_q);
        w_free_ok     = free_vld & w_free_in_range & w_free_busy & ~w_double_free;
    end

    // Busy map, pointer and occupancy for the next cycle.
    always_comb begin
        busy_d = busy_q;
        if (w_grant) begin
            busy_d = busy_d | w_alloc_oh;
        end
        if (w_free_ok) begin
            busy_d = busy_d & ~w_free_oh;
        end

        ptr_d = ptr_q;
        if (w_grant) begin
            ptr_d = (alloc_id_q == C_LAST_ID) ? '0 : alloc_id_q + IDSIZE'(1);
        end

        outstanding_d = outstanding_q
                      + (IDSIZE+1)'(w_grant)
                      - (IDSIZE+1)'(w_free_ok);
        exhausted_d   = (outstanding_d == C_LEN_CNT);
        idle_d        = (outstanding_d == '0);
    end

    // The search looks at the busy map as it will be after this cycle's grant
    // and release, starting from where the pointer will be.
    assign w_free_vec = ~busy_d;

    rr_find_first #(
        .LEN    (LEN),
        .IDSIZE (IDSIZE)
    ) u_find (
        .free_vec_i (w_free_vec),
        .start_i    (ptr_d),
        .found_o    (w_found),
        .index_o    (w_index)
    );

    // Offer register and scoreboard strobes.
    always_comb begin
        alloc_vld_d = alloc_vld_q;
        alloc_id_d  = alloc_id_q;
        if (!w_hold) begin
            alloc_vld_d = w_found;
            alloc_id_d  = w_index;
        end

        set_vld_d   = w_grant;
        set_id_d    = w_grant ? alloc_id_q : set_id_q;
        clear_vld_d = w_free_ok;
        clear_id_d  = w_free_ok ? free_id : clear_id_q;
        err_free_d  = free_vld & ~w_free_ok;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            ptr_q         <= '0;
            alloc_vld_q   <= 1'b0;
            alloc_id_q    <= '0;
            set_vld_q     <= 1'b0;
            set_id_q      <= '0;
            clear_vld_q   <= 1'b0;
            clear_id_q    <= '0;
            outstanding_q <= '0;
            exhausted_q   <= 1'b0;
            idle_q        <= 1'b1;
            err_free_q    <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            ptr_q         <= ptr_d;
            alloc_vld_q   <= alloc_vld_d;
            alloc_id_q    <= alloc_id_d;
            set_vld_q     <= set_vld_d;
            set_id_q      <= set_id_d;
            clear_vld_q   <= clear_vld_d;
            clear_id_q    <= clear_id_d;
            outstanding_q <= outstanding_d;
            exhausted_q   <= exhausted_d;
            idle_q        <= idle_d;
            err_free_q    <= err_free_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alloc_vld   = alloc_vld_q;
    assign alloc_id    = alloc_id_q;
    assign set_vld     = set_vld_q;
    assign set_id      = set_id_q;
    assign clear_vld   = clear_vld_q;
    assign clear_id    = clear_id_q;
    assign outstanding = outstanding_q;
    assign exhausted   = exhausted_q;
    assign idle        = idle_q;
    assign err_free    = err_free_q;

endmodule : axi_id_alloc
`default_nettype wire

// File: tb/tb_axi_id_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_id_alloc
//  Description : Self-checking bench for axi_id_alloc (16-entry pool).
//                Directed scenarios plus a randomized run compared against a
//                pool-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_id_alloc;

    localparam int LEN = 16;
    localparam int IDW = 4;

    logic           clock;
    logic           rst_n;
    logic           alloc_vld;
    logic [IDW-1:0] alloc_id;
    logic           alloc_rdy;
    logic           free_vld;
    logic [IDW-1:0] free_id;
    logic           set_vld;
    logic [IDW-1:0] set_id;
    logic           clear_vld;
    logic [IDW-1:0] clear_id;
    logic [IDW:0]   outstanding;
    logic           exhausted;
    logic           idle;
    logic           err_free;

    int checks = 0;
    int errors = 0;

    axi_id_alloc #(.LEN(LEN)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .alloc_vld   (alloc_vld),
        .alloc_id    (alloc_id),
        .alloc_rdy   (alloc_rdy),
        .free_vld    (free_vld),
        .free_id     (free_id),
        .set_vld     (set_vld),
        .set_id      (set_id),
        .clear_vld   (clear_vld),
        .clear_id    (clear_id),
        .outstanding (outstanding),
        .exhausted   (exhausted),
        .idle        (idle),
        .err_free    (err_free)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Reference model: a set of busy IDs, a search start, the current offer
    // and the strobes the scoreboard should see.
    // ------------------------------------------------------------------------
    bit m_busy[LEN];
    int m_ptr, m_cnt, m_id, m_set_id, m_clr_id;
    bit m_vld, m_set_vld, m_clr_vld, m_err;

    task automatic model_reset();
        for (int i = 0; i < LEN; i++) m_busy[i] = 1'b0;
        m_ptr = 0; m_cnt = 0; m_id = 0; m_set_id = 0; m_clr_id = 0;
        m_vld = 0; m_set_vld = 0; m_clr_vld = 0; m_err = 0;
    endtask

    task automatic model_step(input bit rdy, input bit fv, input int fid);
        bit grant, ok;
        grant = m_vld && rdy;
        ok    = fv && (fid < LEN) && m_busy[fid] && !(grant && fid == m_id);
        m_err     = fv && !ok;
        m_set_vld = grant;
        if (grant) m_set_id = m_id;
        m_clr_vld = ok;
        if (ok) m_clr_id = fid;
        if (grant) begin
            m_busy[m_id] = 1'b1;
            m_ptr = (m_id + 1) % LEN;
            m_cnt++;
        end
        if (ok) begin
            m_busy[fid] = 1'b0;
            m_cnt--;
        end
        if (!(m_vld && !rdy)) begin
            m_vld = 1'b0;
            for (int k = 0; k < LEN; k++) begin
                if (!m_vld && !m_busy[(m_ptr + k) % LEN]) begin
                    m_vld = 1'b1;
                    m_id  = (m_ptr + k) % LEN;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input bit rdy, input bit fv, input int fid);
        alloc_rdy = rdy;
        free_vld  = fv;
        free_id   = IDW'(fid);
        model_step(rdy, fv, fid);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        alloc_rdy = 1'b0;
        free_vld  = 1'b0;
        free_id   = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({alloc_vld, set_vld, clear_vld, exhausted, idle, err_free} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000010",
                     {alloc_vld, set_vld, clear_vld, exhausted, idle, err_free});
        end
        checks++;
        if ({outstanding, alloc_id, set_id, clear_id} !== '0) begin
            errors++;
            $display("FAIL reset_values: outstanding=%0d alloc_id=%0d set_id=%0d clear_id=%0d expected all 0",
                     outstanding, alloc_id, set_id, clear_id);
        end
        cycle(1'b0, 1'b0, 0);
        checks++;
        if ({alloc_vld, alloc_id} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL first_offer: got vld=%0d id=%0d expected vld=1 id=0", alloc_vld, alloc_id);
        end
    endtask

    task automatic test_fill();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < LEN; k++) begin
            checks++;
            if ({alloc_vld, alloc_id} !== {1'b1, IDW'(k)}) begin
                errors++;
                $display("FAIL fill_offer: got vld=%0d id=%0d expected vld=1 id=%0d", alloc_vld, alloc_id, k);
            end
            cycle(1'b1, 1'b0, 0);
            checks++;
            if ({set_vld, set_id, outstanding} !== {1'b1, IDW'(k), 5'(k + 1)}) begin
                errors++;
                $display("FAIL fill_set: got set_vld=%0d set_id=%0d outstanding=%0d expected 1 %0d %0d",
                         set_vld, set_id, outstanding, k, k + 1);
            end
        end
        checks++;
        if ({alloc_vld, exhausted, idle, outstanding} !== {1'b0, 1'b1, 1'b0, 5'd16}) begin
            errors++;
            $display("FAIL fill_exhausted: got vld=%0d exh=%0d idle=%0d out=%0d expected 0 1 0 16",
                     alloc_vld, exhausted, idle, outstanding);
        end
    endtask

    task automatic test_exhaust_free();
        // Pool is full from test_fill.
        cycle(1'b0, 1'b1, 5);
        checks++;
        if ({clear_vld, clear_id, set_vld} !== {1'b1, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL exh_clear: got clear_vld=%0d clear_id=%0d set_vld=%0d expected 1 5 0",
                     clear_vld, clear_id, set_vld);
        end
        checks++;
        if ({alloc_vld, alloc_id, exhausted, outstanding} !== {1'b1, 4'd5, 1'b0, 5'd15}) begin
            errors++;
            $display("FAIL exh_reoffer: got vld=%0d id=%0d exh=%0d out=%0d expected 1 5 0 15",
                     alloc_vld, alloc_id, exhausted, outstanding);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        repeat (4) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 1);
        checks++;
        if ({alloc_vld, alloc_id, outstanding} !== {1'b1, 4'd4, 5'd3}) begin
            errors++;
            $display("FAIL rot_skip: got vld=%0d id=%0d out=%0d expected 1 4 3", alloc_vld, alloc_id, outstanding);
        end
        for (int k = 4; k < LEN; k++) begin
            checks++;
            if (alloc_id !== IDW'(k)) begin
                errors++;
                $display("FAIL rot_seq: got id=%0d expected %0d", alloc_id, k);
            end
            cycle(1'b1, 1'b0, 0);
        end
        checks++;
        if ({alloc_vld, alloc_id, outstanding} !== {1'b1, 4'd1, 5'd15}) begin
            errors++;
            $display("FAIL rot_wrap: got vld=%0d id=%0d out=%0d expected 1 1 15", alloc_vld, alloc_id, outstanding);
        end
    endtask

    task automatic test_hold();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        repeat (2) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        checks++;
        if ({alloc_vld, alloc_id, clear_vld, clear_id} !== {1'b1, 4'd2, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL hold_free: got vld=%0d id=%0d clr=%0d clr_id=%0d expected 1 2 1 0",
                     alloc_vld, alloc_id, clear_vld, clear_id);
        end
        cycle(1'b0, 1'b0, 0);
        checks++;
        if ({alloc_vld, alloc_id} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL hold_stable: got vld=%0d id=%0d expected 1 2", alloc_vld, alloc_id);
        end
        cycle(1'b1, 1'b0, 0);
        checks++;
        if ({set_vld, set_id, alloc_vld, alloc_id} !== {1'b1, 4'd2, 1'b1, 4'd3}) begin
            errors++;
            $display("FAIL hold_accept: got set=%0d set_id=%0d vld=%0d id=%0d expected 1 2 1 3",
                     set_vld, set_id, alloc_vld, alloc_id);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        checks++;
        if ({outstanding, set_vld, set_id, clear_vld, clear_id} !== {5'd3, 1'b1, 4'd3, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL same_cycle: got out=%0d set=%0d/%0d clr=%0d/%0d expected 3 1/3 1/0",
                     outstanding, set_vld, set_id, clear_vld, clear_id);
        end
        cycle(1'b0, 1'b1, 9);
        checks++;
        if ({err_free, outstanding, clear_vld, set_vld, alloc_vld, alloc_id} !==
            {1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 4'd4}) begin
            errors++;
            $display("FAIL err_free_nonbusy: got err=%0d out=%0d clr=%0d set=%0d vld=%0d id=%0d expected 1 3 0 0 1 4",
                     err_free, outstanding, clear_vld, set_vld, alloc_vld, alloc_id);
        end
        cycle(1'b0, 1'b0, 0);
        checks++;
        if (err_free !== 1'b0) begin
            errors++;
            $display("FAIL err_free_pulse: got err=%0d expected 0", err_free);
        end
        cycle(1'b1, 1'b1, 4);
        checks++;
        if ({err_free, outstanding, clear_vld, set_vld, set_id} !== {1'b1, 5'd4, 1'b0, 1'b1, 4'd4}) begin
            errors++;
            $display("FAIL double_free: got err=%0d out=%0d clr=%0d set=%0d/%0d expected 1 4 0 1/4",
                     err_free, outstanding, clear_vld, set_vld, set_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 0);
        repeat (7) cycle(1'b1, 1'b0, 0);
        checks++;
        if (outstanding !== 5'd7) begin
            errors++;
            $display("FAIL arst_pre: got out=%0d expected 7", outstanding);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({alloc_vld, set_vld, clear_vld, exhausted, idle, err_free, outstanding} !== {6'b000010, 5'd0}) begin
            errors++;
            $display("FAIL arst_now: got flags=%b out=%0d expected 000010 0",
                     {alloc_vld, set_vld, clear_vld, exhausted, idle, err_free}, outstanding);
        end
        alloc_rdy = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0);
        checks++;
        if ({alloc_vld, alloc_id, idle} !== {1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL arst_reoffer: got vld=%0d id=%0d idle=%0d expected 1 0 1", alloc_vld, alloc_id, idle);
        end
    endtask

    task automatic test_random();
        bit r, f;
        int id;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(99) < 75);
            f  = ($urandom_range(99) < 40);
            id = int'($urandom_range(LEN - 1));
            cycle(r, f, id);
            checks++;
            if ({alloc_vld, outstanding, exhausted, idle, set_vld, clear_vld, err_free} !==
                {m_vld, 5'(m_cnt), m_cnt == LEN, m_cnt == 0, m_set_vld, m_clr_vld, m_err}) begin
                errors++;
                $display("FAIL rnd_status @%0d: got vld=%0d out=%0d exh=%0d idle=%0d set=%0d clr=%0d err=%0d expected %0d %0d %0d %0d %0d %0d %0d",
                         n, alloc_vld, outstanding, exhausted, idle, set_vld, clear_vld, err_free,
                         m_vld, m_cnt, m_cnt == LEN, m_cnt == 0, m_set_vld, m_clr_vld, m_err);
            end
            if (m_vld) begin
                checks++;
                if (alloc_id !== IDW'(m_id)) begin
                    errors++;
                    $display("FAIL rnd_alloc_id @%0d: got %0d expected %0d", n, alloc_id, m_id);
                end
            end
            if (m_set_vld) begin
                checks++;
                if (set_id !== IDW'(m_set_id)) begin
                    errors++;
                    $display("FAIL rnd_set_id @%0d: got %0d expected %0d", n, set_id, m_set_id);
                end
            end
            if (m_clr_vld) begin
                checks++;
                if (clear_id !== IDW'(m_clr_id)) begin
                    errors++;
                    $display("FAIL rnd_clear_id @%0d: got %0d expected %0d", n, clear_id, m_clr_id);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        alloc_rdy = 1'b0;
        free_vld  = 1'b0;
        free_id   = '0;
        test_reset();
        test_fill();
        test_exhaust_free();
        test_rotation();
        test_hold();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_axi_id_alloc
`default_nettype wire

// File: doc/axi_id_alloc.md
Name: axi_id_alloc

Overview:
Allocates free AXI transaction IDs to a request issuer through a valid/ready handshake. Takes IDs back when their responses retire. Keeps a busy bitmap and searches it with a rotating pointer, so an ID is not reissued immediately after it is released. Sits directly upstream of the per-ID outstanding scoreboard and drives that scoreboard's set and clear strobes.

Parameters:
LEN, 16, number of IDs in the pool; any integer ≥2.
IDSIZE, $clog2(LEN), ID width.

Ports:
clock  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
alloc_vld  output  1  an ID is offered
alloc_id  output  IDSIZE  offered ID
alloc_rdy  input  1  issuer takes the offered ID
free_vld  input  1  release strobe
free_id  input  IDSIZE  ID being released
set_vld  output  1  scoreboard set strobe
set_id  output  IDSIZE  scoreboard set ID
clear_vld  output  1  scoreboard clear strobe
clear_id  output  IDSIZE  scoreboard clear ID
outstanding  output  IDSIZE+1  number of busy IDs
exhausted  output  1  all LEN IDs busy
idle  output  1  no ID busy
err_free  output  1  one-cycle pulse on an illegal release

Behaviour:
- Reset: busy=0, ptr=0, and every output is 0 except idle=1. Reset is async assert, sync-to-clock deassert usage. Asserting rst_n mid-operation drops all state in the same cycle; the handshake in flight is lost.
- grant = alloc_vld & alloc_rdy.
- Valid release: free_vld & busy[free_id] & free_id<LEN. Any other free_vld is ignored and pulses err_free the next cycle.
  - A release of an ID equal to the alloc_id accepted in the same cycle is a double free. It is ignored and flagged.
- busy_next = busy | onehot(alloc_id) when grant, then & ~onehot(free_id) when the release is valid. Both apply in one cycle when the IDs differ.
- ptr: on grant, ptr ← alloc_id+1, wrapping to 0 when alloc_id = LEN-1. Otherwise ptr holds.
- Offer register:
  - If alloc_vld & ~alloc_rdy, alloc_vld and alloc_id hold; the offer is stable until accepted.
  - Otherwise, next cycle: alloc_vld = |~busy_next and alloc_id = first i with ~busy_next[i], searching ptr_next, ptr_next+1, … with wrap at LEN.
  - Back-to-back grants every cycle are supported.
- Latency:
  - A freed ID is offerable one cycle after free_vld, but only if no offer is held pending.
  - The first offer appears on the first clock edge after reset release.
- Scoreboard strobes are registered one cycle after the event:
  - set_vld/set_id from grant.
  - clear_vld/clear_id from a valid release.
- outstanding: +1 on grant, −1 on valid release, unchanged when both occur. It is registered and never exceeds LEN.
- exhausted = (outstanding_next == LEN), registered.
- idle = (outstanding_next == 0), registered.
- When exhausted, alloc_vld=0. A release re-arms the offer one cycle later.
- alloc_rdy while alloc_vld=0 has no effect.

Decomposition:
- Shared package axi_id_pkg: the function rot_first_free(vec, start) returning {found, index}, plus a localparam default ID_POOL_LEN=16.
- One natural sub-module: rr_find_first. It is a combinational rotating priority encoder, parameterised by LEN. It takes the inverted busy_next vector and the start pointer, and returns found/index. It is instantiated once.
- All state (busy, ptr, offer, counters, strobes) lives in axi_id_alloc.

Test Plan:
1. Reset release, alloc_rdy=1 continuously:
   - IDs 0,1,2,…,15 are granted on consecutive cycles.
   - Then alloc_vld=0 and exhausted=1 with outstanding=16.
   - set_vld follows each grant by one cycle with matching set_id.
2. Exhaust the pool, then free_vld with free_id=5:
   - clear_vld=1, clear_id=5 one cycle later.
   - alloc_vld=1, alloc_id=5 one cycle after the free; exhausted=0.
3. Grant IDs 0–3, free ID 1:
   - The next offer is 4, not 1, because the rotating pointer is at 4.
   - After 4…15 are granted, the search wraps and offers 1.
4. Hold alloc_rdy=0 with alloc_id=2 offered, then free ID 0 (busy):
   - alloc_id stays 2 and alloc_vld stays 1 until alloc_rdy=1.
5. Same-cycle grant of ID 3 with free of busy ID 0:
   - outstanding is unchanged.
   - set_id=3 and clear_id=0 appear together next cycle.
   - Free of non-busy ID 9 → err_free=1 for one cycle and state unchanged.
6. With outstanding=7, assert rst_n=0 asynchronously mid-cycle:
   - All outputs go immediately to reset values; idle=1.
   - After release, ID 0 is offered again.
